// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the staged reset-release controller.
package reset_sequencer_pkg;

    // Controller phases: hold all domains, release them in order, run, serve a soft reset.
    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_SOFT    = 2'd3
    } state_t;

    // Width of a counter that must reach the largest of the three cycle parameters.
    function automatic int cnt_width(input int hold_c, input int step_c, input int pulse_c);
        int m;
        m = hold_c;
        if (step_c > m) m = step_c;
        if (pulse_c > m) m = pulse_c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Request/status bundle between the reset sequencer and its software-facing master.
//
// Handshake: soft_reset_all and soft_reset_req are single-cycle request pulses with
// no backpressure; a request is either accepted into the pending set or dropped
// (during hold/release, or for the domain already being reset). soft_reset_ack is a
// single-cycle completion pulse per domain. ready/busy/domain_rst/state are levels.
interface reset_sequencer_if
    import reset_sequencer_pkg::*;
#(
    parameter int DOMAINS = 4
);
    logic               soft_reset_all;
    logic [DOMAINS-1:0] soft_reset_req;
    logic [DOMAINS-1:0] domain_rst;
    logic [DOMAINS-1:0] soft_reset_ack;
    logic               ready;
    logic               busy;
    state_t             state;

    modport master (
        output soft_reset_all, soft_reset_req,
        input  domain_rst, soft_reset_ack, ready, busy, state
    );

    modport slave (
        input  soft_reset_all, soft_reset_req,
        output domain_rst, soft_reset_ack, ready, busy, state
    );
endinterface

// File: rtl/reset_sequencer_priority_select.sv
// Lowest-index-wins selector over the pending soft-reset requests.
module reset_sequencer_priority_select #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);
    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        grant = '0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                index    = IW'(i);
            end
        end
    end
endmodule

// File: rtl/reset_sequencer.sv
// Staged reset-release controller: holds every domain after reset, releases them
// one by one in index order, then serves global and per-domain soft resets.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int DOMAINS           = 4,
    parameter int HOLD_CYCLES       = 16,
    parameter int STEP_CYCLES       = 8,
    parameter int SOFT_PULSE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    reset_sequencer_if.slave bus
);
    localparam int CW = cnt_width(HOLD_CYCLES, STEP_CYCLES, SOFT_PULSE_CYCLES);
    localparam int IW = $clog2(DOMAINS);

    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STEP_LAST  = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(SOFT_PULSE_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DOMAINS - 1);

    state_t             state_q, state_n;
    logic [CW-1:0]      count_q, count_n;
    logic [IW-1:0]      idx_q, idx_n;
    logic [IW-1:0]      sel_q, sel_n;
    logic [DOMAINS-1:0] pending_q, pending_n;
    logic [DOMAINS-1:0] domain_rst_q, domain_rst_n;
    logic [DOMAINS-1:0] ack_q, ack_n;
    logic               ready_q, ready_n;
    logic               busy_q;

    logic [DOMAINS-1:0] grant;
    logic [IW-1:0]      grant_idx;
    logic [DOMAINS-1:0] sel_mask;

    reset_sequencer_priority_select #(
        .N  (DOMAINS),
        .IW (IW)
    ) u_prio (
        .req   (pending_q),
        .grant (grant),
        .index (grant_idx)
    );

    // One-hot mask of the domain currently under soft reset.
    always_comb begin
        sel_mask        = '0;
        sel_mask[sel_q] = 1'b1;
    end

    // Next-state, counter, pending-set and output computation.
    always_comb begin
        state_n      = state_q;
        count_n      = count_q;
        idx_n        = idx_q;
        sel_n        = sel_q;
        pending_n    = pending_q;
        domain_rst_n = domain_rst_q;
        ack_n        = '0;
        ready_n      = ready_q;

        // New requests only collect once the domains are up; the domain being
        // reset right now cannot queue a second reset for itself.
        if (state_q == ST_RUN) begin
            pending_n = pending_q | bus.soft_reset_req;
        end else if (state_q == ST_SOFT) begin
            pending_n = pending_q | (bus.soft_reset_req & ~sel_mask);
        end

        unique case (state_q)
            ST_HOLD: begin
                if (count_q == HOLD_LAST) begin
                    state_n = ST_RELEASE;
                    count_n = '0;
                    idx_n   = '0;
                end else begin
                    count_n = count_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (count_q == STEP_LAST) begin
                    domain_rst_n[idx_q] = 1'b0;
                    count_n             = '0;
                    idx_n               = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        ready_n = 1'b1;
                        state_n = ST_RUN;
                    end
                end else begin
                    count_n = count_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (pending_q != '0) begin
                    domain_rst_n = domain_rst_q | grant;
                    ready_n      = 1'b0;
                    count_n      = '0;
                    sel_n        = grant_idx;
                    state_n      = ST_SOFT;
                end
            end
            ST_SOFT: begin
                if (count_q == PULSE_LAST) begin
                    domain_rst_n[sel_q] = 1'b0;
                    pending_n[sel_q]    = 1'b0;
                    ack_n[sel_q]        = 1'b1;
                    state_n             = ST_RUN;
                    ready_n             = (pending_n == '0);
                end else begin
                    count_n = count_q + 1'b1;
                end
            end
            default: begin
                state_n = ST_HOLD;
            end
        endcase

        // A global soft reset overrides everything, including an in-flight pulse.
        if (bus.soft_reset_all) begin
            state_n      = ST_HOLD;
            count_n      = '0;
            pending_n    = '0;
            domain_rst_n = '1;
            ack_n        = '0;
            ready_n      = 1'b0;
        end
    end

    // State and output registers; rst aborts any operation and re-holds all domains.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HOLD;
            count_q      <= '0;
            idx_q        <= '0;
            sel_q        <= '0;
            pending_q    <= '0;
            domain_rst_q <= '1;
            ack_q        <= '0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_n;
            count_q      <= count_n;
            idx_q        <= idx_n;
            sel_q        <= sel_n;
            pending_q    <= pending_n;
            domain_rst_q <= domain_rst_n;
            ack_q        <= ack_n;
            ready_q      <= ready_n;
            busy_q       <= (state_n != ST_RUN);
        end
    end

    assign bus.domain_rst     = domain_rst_q;
    assign bus.soft_reset_ack = ack_q;
    assign bus.ready          = ready_q;
    assign bus.busy           = busy_q;
    assign bus.state          = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus random pulses, checked every
// cycle against a timestamp-based model of the release schedule and soft resets.
module tb_reset_sequencer;
    import reset_sequencer_pkg::*;

    localparam int D     = 4;
    localparam int HOLD  = 16;
    localparam int STEP  = 8;
    localparam int SOFTP = 4;
    localparam int W     = 2 * D + 2;

    logic clk = 1'b0;
    logic rst;

    reset_sequencer_if #(.DOMAINS(D)) bus ();

    reset_sequencer #(
        .DOMAINS           (D),
        .HOLD_CYCLES       (HOLD),
        .STEP_CYCLES       (STEP),
        .SOFT_PULSE_CYCLES (SOFTP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int base   = 0;

    logic [W-1:0] exp_q[$];

    // ---------------- reference model ----------------
    function automatic int lowest(input logic [D-1:0] v);
        int r;
        r = -1;
        for (int i = D - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    // Expected outputs after each edge, from when the sequence started and when
    // the current soft reset began.
    initial begin
        int now;
        int done_t;
        int seq_t0;
        int serving;
        int serve_start;
        logic [D-1:0] pend;
        logic [D-1:0] old;
        logic [D-1:0] keep;
        logic [D-1:0] e_drst;
        logic [D-1:0] e_ack;
        logic e_ready;
        logic e_busy;
        seq_t0      = 0;
        serving     = -1;
        serve_start = 0;
        pend        = '0;
        forever begin
            @(posedge clk);
            cyc    = cyc + 1;
            now    = cyc;
            e_ack  = '0;
            e_drst = '1;
            if (rst || bus.soft_reset_all) begin
                seq_t0  = now;
                serving = -1;
                pend    = '0;
                e_ready = 1'b0;
                e_busy  = 1'b1;
            end else begin
                done_t = seq_t0 + HOLD + STEP * D;
                if (now <= done_t) begin
                    for (int k = 0; k < D; k++)
                        e_drst[k] = (now < seq_t0 + HOLD + STEP * (k + 1));
                    e_ready = (now == done_t);
                    e_busy  = !e_ready;
                end else if (serving >= 0) begin
                    keep          = '1;
                    keep[serving] = 1'b0;
                    pend          = pend | (bus.soft_reset_req & keep);
                    if (now == serve_start + SOFTP) begin
                        pend[serving]  = 1'b0;
                        e_ack[serving] = 1'b1;
                        serving        = -1;
                        e_ready        = (pend == '0);
                        e_busy         = 1'b0;
                    end else begin
                        e_ready = 1'b0;
                        e_busy  = 1'b1;
                    end
                end else begin
                    old  = pend;
                    pend = pend | bus.soft_reset_req;
                    if (old != '0) begin
                        serving     = lowest(old);
                        serve_start = now;
                        e_ready     = 1'b0;
                        e_busy      = 1'b1;
                    end else begin
                        e_ready = 1'b1;
                        e_busy  = 1'b0;
                    end
                end
                if (now > done_t) begin
                    e_drst = '0;
                    if (serving >= 0) e_drst[serving] = 1'b1;
                end
            end
            exp_q.push_back({e_drst, e_ack, e_ready, e_busy});
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [W-1:0] got;
        logic [W-1:0] exp;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp    = exp_q.pop_front();
                got    = {bus.domain_rst, bus.soft_reset_ack, bus.ready, bus.busy};
                checks = checks + 1;
                if (got !== exp) begin
                    errors = errors + 1;
                    $display("FAIL outputs @edge %0d: got drst=%b ack=%b ready=%b busy=%b, expected drst=%b ack=%b ready=%b busy=%b",
                             cyc, got[W-1 -: D], got[D+1 -: D], got[1], got[0],
                             exp[W-1 -: D], exp[D+1 -: D], exp[1], exp[0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic release_rst();
        rst  = 1'b0;
        base = cyc;
    endtask

    task automatic hold_rst(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        release_rst();
    endtask

    // Drive one-cycle request pulses; e_at is the edge that sampled them.
    task automatic pulse(input logic all, input logic [D-1:0] req, output int e_at);
        bus.soft_reset_all = all;
        bus.soft_reset_req = req;
        @(negedge clk);
        e_at               = cyc;
        bus.soft_reset_all = 1'b0;
        bus.soft_reset_req = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e;
        rst                = 1'b1;
        bus.soft_reset_all = 1'b0;
        bus.soft_reset_req = '0;

        // Power-up
        @(negedge clk);
        check("reset_drst", bus.domain_rst, 4'b1111);
        check("reset_ready_busy", {bus.ready, bus.busy}, 2'b01);
        repeat (4) @(negedge clk);
        release_rst();
        wait_until(base + 23); check("pwr_edge23", bus.domain_rst, 4'b1111);
        wait_until(base + 24); check("pwr_edge24", bus.domain_rst, 4'b1110);
        wait_until(base + 32); check("pwr_edge32", bus.domain_rst, 4'b1100);
        wait_until(base + 40); check("pwr_edge40", bus.domain_rst, 4'b1000);
        wait_until(base + 47); check("pwr_ready47", bus.ready, 1'b0);
        wait_until(base + 48); check("pwr_edge48", bus.domain_rst, 4'b0000);
        check("pwr_ready_busy48", {bus.ready, bus.busy}, 2'b10);

        // Soft reset of a single domain
        repeat (3) @(negedge clk);
        pulse(1'b0, 4'b0100, e);
        wait_until(e + 1); check("soft_start", {bus.domain_rst, bus.ready}, 5'b0100_0);
        wait_until(e + 4); check("soft_held", bus.domain_rst, 4'b0100);
        wait_until(e + 5); check("soft_done", {bus.domain_rst, bus.soft_reset_ack, bus.ready}, 9'b0000_0100_1);

        // Arbitration between two requests
        repeat (3) @(negedge clk);
        pulse(1'b0, 4'b1010, e);
        wait_until(e + 5); check("arb_ack1", {bus.soft_reset_ack, bus.ready}, 5'b0010_0);
        wait_until(e + 6); check("arb_second", bus.domain_rst, 4'b1000);
        wait_until(e + 10); check("arb_ack3", {bus.soft_reset_ack, bus.ready}, 5'b1000_1);

        // Global soft reset together with a per-domain request
        repeat (3) @(negedge clk);
        pulse(1'b1, 4'b0001, e);
        check("glob_drst", {bus.domain_rst, bus.busy}, 5'b1111_1);
        wait_until(e + 24); check("glob_edge24", bus.domain_rst, 4'b1110);
        wait_until(e + 48); check("glob_ready", bus.ready, 1'b1);

        // Abort mid-release
        repeat (3) @(negedge clk);
        hold_rst(3);
        wait_until(base + 34);
        rst = 1'b1;
        @(negedge clk);
        check("abort_drst", {bus.domain_rst, bus.ready}, 5'b1111_0);
        @(negedge clk);
        release_rst();
        wait_until(base + 24); check("abort_edge24", bus.domain_rst, 4'b1110);
        wait_until(base + 48); check("abort_edge48", {bus.domain_rst, bus.ready}, 5'b0000_1);

        // Request during hold is ignored
        hold_rst(2);
        wait_until(base + 5);
        pulse(1'b0, 4'b0001, e);
        wait_until(base + 58);
        check("ignore_idle", {bus.domain_rst, bus.busy, bus.ready}, 6'b0000_01);

        // Random pulses
        for (int i = 0; i < 3000; i++) begin
            bus.soft_reset_req = ($urandom_range(0, 4) == 0) ? D'($urandom_range(1, (1 << D) - 1)) : '0;
            bus.soft_reset_all = ($urandom_range(0, 299) == 0);
            rst                = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        rst                = 1'b0;
        bus.soft_reset_all = 1'b0;
        bus.soft_reset_req = '0;
        repeat (80) @(negedge clk);
        check("final_ready", {bus.domain_rst, bus.ready, bus.busy}, 6'b0000_10);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
